// File: rtl/data_sram_like_responder_pkg.sv
// Shared types and defaults for the SRAM-like data-side responder model.
// Included by the top level and by its response FIFO.
package data_sram_like_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int DEF_DEPTH   = 4;
  localparam int DEF_LATENCY = 2;

  // The age field is 8 bits wide, so LATENCY must stay below 256.
  localparam int AGE_W = 8;

  typedef struct packed {
    logic             wr;
    logic [31:0]      data;
    logic [AGE_W-1:0] age;
  } entry_t;

endpackage

// File: rtl/sram_like_resp_fifo.sv
// In-order queue of outstanding responses.
// Each entry carries an age counter that saturates at LATENCY.
module sram_like_resp_fifo
  import data_sram_like_responder_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   push_wr,
  input  logic [31:0]            push_data,
  input  logic                   pop,
  output logic                   head_wr,
  output logic [31:0]            head_data,
  output logic                   head_ripe,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t           entries_q [DEPTH];
  entry_t           entries_d [DEPTH];
  logic [PTR_W-1:0] slot_off  [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off[i] = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, slot_off[i]} < count_q) && (entries_q[i].age < AGE_W'(LATENCY)))
        entries_d[i].age = entries_q[i].age + 1'b1;
    end
    // A fresh entry already has one edge behind it, so it starts at age 1;
    // that makes the earliest data_ok land exactly LATENCY cycles after acceptance.
    if (push) begin
      entries_d[wr_ptr_q] = '{wr: push_wr, data: push_data, age: AGE_W'(1)};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i].age <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

  assign head_wr   = entries_q[rd_ptr_q].wr;
  assign head_data = entries_q[rd_ptr_q].data;
  assign head_ripe = entries_q[rd_ptr_q].age >= AGE_W'(LATENCY);
  assign count     = count_q;
  assign full      = count_q == CNT_W'(DEPTH);
  assign empty     = count_q == '0;

  assert property (@(posedge clk) disable iff (reset) !(pop && empty));
  assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/data_sram_like_responder.sv
// Responder end of the SRAM-like data interface.
// It holds a byte-strobed word memory and returns responses in order after a minimum latency.
module data_sram_like_responder
  import data_sram_like_responder_pkg::*;
#(
  parameter int MEM_AW  = 10,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  input  logic        addr_stall,
  input  logic        data_stall
);

  logic [31:0]           mem_q [2**MEM_AW];
  logic [MEM_AW-1:0]     word_idx;
  logic [31:0]           snapshot, head_data;
  logic                  push, pop, full, empty, head_wr, head_ripe;
  logic [$clog2(DEPTH):0] count;
  logic                  unused_ok;

  assign word_idx = addr[MEM_AW+1:2];
  assign snapshot = mem_q[word_idx];

  // Full looks only at the registered count, so data_stall never reaches addr_ok.
  assign addr_ok = req & ~reset & ~addr_stall & ~full;
  assign data_ok = ~reset & ~empty & head_ripe & ~data_stall;
  assign rdata   = (data_ok & ~head_wr) ? head_data : 32'h0;
  assign push    = addr_ok;
  assign pop     = data_ok;

  always_ff @(posedge clk) begin
    if (push && wr) begin
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) mem_q[word_idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  sram_like_resp_fifo #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_wr   (wr),
    .push_data (snapshot),
    .pop       (pop),
    .head_wr   (head_wr),
    .head_data (head_data),
    .head_ripe (head_ripe),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign unused_ok = ^{size, addr[31:MEM_AW+2], addr[1:0], count};

  assert property (@(posedge clk) disable iff (reset) (push && wr) |-> (wstrb != 4'b0000));

endmodule
